// File: rtl/caches_types_pkg.sv
// Cache-side types: state encoding of the bus / coherence controller.
package caches_types_pkg;
   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      IFETCH   = 4'd1,
      WB       = 4'd2,
      SNOOP    = 4'd3,
      SNOOPCHK = 4'd4,
      FWD0     = 4'd5,
      FWD1     = 4'd6,
      RD0      = 4'd7,
      RD1      = 4'd8,
      INV      = 4'd9,
      INVDONE  = 4'd10
   } cc_state_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and the RAM handshake state.
package cpu_types_pkg;
   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'b00,
      BUSY   = 2'b01,
      ACCESS = 2'b10,
      ERROR  = 2'b11
   } ramstate_t;
endpackage

// File: rtl/coherence_ctrl_rr_arb2.sv
// Two-requester round-robin grant: prio names the requester favoured this round.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       prio,
   output logic       valid,
   output logic       grant
);
   always_comb begin
      valid = |req;
      grant = req[prio] ? prio : ~prio;
   end
endmodule

// File: rtl/coherence_ctrl.sv
// Snooping bus controller for two I/D cache pairs sharing one single-ported RAM.
module coherence_ctrl
   import cpu_types_pkg::*;
   import caches_types_pkg::*;
#(
   parameter int CPUS = 2
) (
   input  logic            CLK,
   input  logic            nRST,
   input  logic [CPUS-1:0] iREN,
   input  word_t           iaddr [CPUS],
   output logic [CPUS-1:0] iwait,
   output word_t           iload [CPUS],
   input  logic [CPUS-1:0] dREN,
   input  logic [CPUS-1:0] dWEN,
   input  word_t           daddr [CPUS],
   input  word_t           dstore [CPUS],
   input  logic [CPUS-1:0] cctrans,
   input  logic [CPUS-1:0] ccwrite,
   output logic [CPUS-1:0] dwait,
   output word_t           dload [CPUS],
   output logic [CPUS-1:0] ccwait,
   output logic [CPUS-1:0] ccinv,
   output word_t           ccsnoopaddr [CPUS],
   output logic            ramREN,
   output logic            ramWEN,
   output word_t           ramaddr,
   output word_t           ramstore,
   input  word_t           ramload,
   input  ramstate_t       ramstate
);
   cc_state_t state, state_n;
   logic      req, req_n;
   logic      drr, drr_n;
   logic      irr, irr_n;
   logic      peer;
   logic      d_valid, d_grant;
   logic      i_valid, i_grant;
   logic      ram_access;
   logic      snoop_hold;

   assign peer       = ~req;
   assign ram_access = (ramstate == ACCESS);
   assign snoop_hold = state inside {SNOOP, SNOOPCHK, FWD0, FWD1, RD0, RD1};

   rr_arb2 u_darb (
      .req   (dWEN | dREN | cctrans),
      .prio  (drr),
      .valid (d_valid),
      .grant (d_grant)
   );

   rr_arb2 u_iarb (
      .req   (iREN),
      .prio  (irr),
      .valid (i_valid),
      .grant (i_grant)
   );

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         req   <= 1'b0;
         drr   <= 1'b0;
         irr   <= 1'b0;
      end else begin
         state <= state_n;
         req   <= req_n;
         drr   <= drr_n;
         irr   <= irr_n;
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_n = state;
      req_n   = req;
      drr_n   = drr;
      irr_n   = irr;
      case (state)
         IDLE: begin
            if (d_valid) begin
               req_n = d_grant;
               if (dWEN[d_grant])                          state_n = WB;
               else if (dREN[d_grant])                     state_n = SNOOP;
               else if (cctrans[d_grant] & ccwrite[d_grant]) state_n = INV;
            end else if (i_valid) begin
               req_n   = i_grant;
               state_n = IFETCH;
            end
         end
         IFETCH: if (ram_access) begin
            irr_n   = ~req;
            state_n = IDLE;
         end
         // Holding WB while dWEN stays up keeps a two-word writeback contiguous.
         WB: if (!dWEN[req]) begin
            drr_n   = ~req;
            state_n = IDLE;
         end
         SNOOP:    state_n = SNOOPCHK;
         SNOOPCHK: state_n = cctrans[peer] ? FWD0 : RD0;
         FWD0:     if (ram_access) state_n = FWD1;
         FWD1: if (ram_access) begin
            drr_n   = ~req;
            state_n = IDLE;
         end
         RD0:      if (ram_access) state_n = RD1;
         RD1: if (ram_access) begin
            drr_n   = ~req;
            state_n = IDLE;
         end
         INV:      state_n = INVDONE;
         INVDONE: begin
            drr_n   = ~req;
            state_n = IDLE;
         end
         default:  state_n = IDLE;
      endcase
   end

   always_comb begin
      iwait    = '1;
      dwait    = '1;
      ccwait   = '0;
      ccinv    = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      for (int i = 0; i < CPUS; i++) begin
         iload[i]       = ramload;
         dload[i]       = ramload;
         ccsnoopaddr[i] = '0;
      end

      if (snoop_hold) begin
         ccwait[peer]      = 1'b1;
         ccinv[peer]       = ccwrite[req];
         ccsnoopaddr[peer] = daddr[req];
      end

      case (state)
         IFETCH: begin
            ramREN  = 1'b1;
            ramaddr = iaddr[req];
            if (ram_access) iwait[req] = 1'b0;
         end
         WB: begin
            ramWEN   = dWEN[req];
            ramaddr  = daddr[req];
            ramstore = dstore[req];
            if (ram_access) dwait[req] = 1'b0;
         end
         // Dirty peer data goes to the requester and back to RAM in the same cycle.
         FWD0, FWD1: begin
            ramWEN     = 1'b1;
            ramaddr    = daddr[peer];
            ramstore   = dstore[peer];
            dload[req] = dstore[peer];
            if (ram_access) begin
               dwait[req]  = 1'b0;
               dwait[peer] = 1'b0;
            end
         end
         RD0, RD1: begin
            ramREN  = 1'b1;
            ramaddr = daddr[req];
            if (ram_access) dwait[req] = 1'b0;
         end
         INV: begin
            ccwait[peer]      = 1'b1;
            ccinv[peer]       = 1'b1;
            ccsnoopaddr[peer] = daddr[req];
         end
         INVDONE: dwait[req] = 1'b0;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_coherence_ctrl.sv
// Directed cycle-by-cycle vectors for coherence_ctrl plus a RAM-stall sequence.
module tb_coherence_ctrl;
   import cpu_types_pkg::*;

   logic       CLK = 1'b0;
   logic       nRST;
   logic [1:0] iREN, dREN, dWEN, cctrans, ccwrite;
   word_t      iaddr [2];
   word_t      daddr [2];
   word_t      dstore [2];
   logic [1:0] iwait, dwait, ccwait, ccinv;
   word_t      iload [2];
   word_t      dload [2];
   word_t      ccsnoopaddr [2];
   logic       ramREN, ramWEN;
   word_t      ramaddr, ramstore, ramload;
   ramstate_t  ramstate;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   coherence_ctrl #(.CPUS(2)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .cctrans(cctrans), .ccwrite(ccwrite), .dwait(dwait), .dload(dload),
      .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   typedef struct {
      string      nm;
      logic       nrst;
      logic [1:0] iren, dren, dwen, cct, ccw;
      ramstate_t  rs;
      word_t      rl, da0, da1, ds0, ds1;
      logic [1:0] iw, dw, cw, ci;
      logic       ren, wen;
      word_t      ra, rst, dl0, dl1, sn0, sn1;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(string nm, logic nrst, logic [1:0] iren, dren, dwen, cct, ccw,
                               ramstate_t rs, word_t rl, da0, da1, ds0, ds1,
                               logic [1:0] iw, dw, cw, ci, logic ren, wen,
                               word_t ra, rst, dl0, dl1, sn0, sn1);
      vec_t v;
      v.nm = nm; v.nrst = nrst; v.iren = iren; v.dren = dren; v.dwen = dwen;
      v.cct = cct; v.ccw = ccw; v.rs = rs; v.rl = rl; v.da0 = da0; v.da1 = da1;
      v.ds0 = ds0; v.ds1 = ds1; v.iw = iw; v.dw = dw; v.cw = cw; v.ci = ci;
      v.ren = ren; v.wen = wen; v.ra = ra; v.rst = rst; v.dl0 = dl0; v.dl1 = dl1;
      v.sn0 = sn0; v.sn1 = sn1;
      vecs.push_back(v);
   endfunction

   task automatic check(string nm, logic [287:0] act, logic [287:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [287:0] outs();
      return {iwait, dwait, ccwait, ccinv, ramREN, ramWEN, ramaddr, ramstore,
              dload[0], dload[1], ccsnoopaddr[0], ccsnoopaddr[1], iload[0], iload[1]};
   endfunction

   function automatic logic [287:0] expect_of(vec_t v);
      return {v.iw, v.dw, v.cw, v.ci, v.ren, v.wen, v.ra, v.rst,
              v.dl0, v.dl1, v.sn0, v.sn1, v.rl, v.rl};
   endfunction

   task automatic apply(vec_t v);
      @(negedge CLK);
      nRST = v.nrst; iREN = v.iren; dREN = v.dren; dWEN = v.dwen;
      cctrans = v.cct; ccwrite = v.ccw; ramstate = v.rs; ramload = v.rl;
      daddr[0] = v.da0; daddr[1] = v.da1; dstore[0] = v.ds0; dstore[1] = v.ds1;
      #1;
      check(v.nm, outs(), expect_of(v));
   endtask

   initial begin
      bit found;
      nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
      iaddr[0] = 32'h40; iaddr[1] = 32'h80;
      daddr[0] = '0; daddr[1] = '0; dstore[0] = '0; dstore[1] = '0;
      ramstate = FREE; ramload = 32'hDEAD;

      // Core0 read miss, clean peer: snoop then two RAM words (one BUSY stall).
      add("a1_grant",  1,0,2'b01,0,0,0, FREE,  0,        'h100,0,0,0, 3,3,0,0,0,0, 0,0,0,0,0,0);
      add("a2_snoop",  1,0,2'b01,0,0,0, FREE,  0,        'h100,0,0,0, 3,3,2'b10,0,0,0, 0,0,0,0,0,'h100);
      add("a3_snpchk", 1,0,2'b01,0,0,0, FREE,  0,        'h100,0,0,0, 3,3,2'b10,0,0,0, 0,0,0,0,0,'h100);
      add("a4_rd0_bsy",1,0,2'b01,0,0,0, BUSY,  0,        'h100,0,0,0, 3,3,2'b10,0,1,0, 'h100,0,0,0,0,'h100);
      add("a5_rd0",    1,0,2'b01,0,0,0, ACCESS,'hAAAA,   'h100,0,0,0, 3,2'b10,2'b10,0,1,0, 'h100,0,'hAAAA,'hAAAA,0,'h100);
      add("a6_rd1",    1,0,2'b01,0,0,0, ACCESS,'hBBBB,   'h104,0,0,0, 3,2'b10,2'b10,0,1,0, 'h104,0,'hBBBB,'hBBBB,0,'h104);
      // Core1 BusRdX, core0 dirty: forward to core1 and RAM, both dwait low together.
      add("b1_grant",  1,0,2'b10,0,2'b10,2'b10, FREE,0, 0,'h200,0,0, 3,3,0,0,0,0, 0,0,0,0,0,0);
      add("b2_snoop",  1,0,2'b10,0,2'b10,2'b10, FREE,0, 0,'h200,0,0, 3,3,2'b01,2'b01,0,0, 0,0,0,0,'h200,0);
      add("b3_snpchk", 1,0,2'b10,0,2'b11,2'b10, FREE,0, 'h200,'h200,'h11,0, 3,3,2'b01,2'b01,0,0, 0,0,0,0,'h200,0);
      add("b4_fwd0_bsy",1,0,2'b10,0,2'b11,2'b10, BUSY,0, 'h200,'h200,'h11,0, 3,3,2'b01,2'b01,0,1, 'h200,'h11,0,'h11,'h200,0);
      add("b5_fwd0",   1,0,2'b10,0,2'b11,2'b10, ACCESS,0, 'h200,'h200,'h11,0, 3,0,2'b01,2'b01,0,1, 'h200,'h11,0,'h11,'h200,0);
      add("b6_fwd1",   1,0,2'b10,0,2'b11,2'b10, ACCESS,0, 'h204,'h204,'h22,0, 3,0,2'b01,2'b01,0,1, 'h204,'h22,0,'h22,'h204,0);
      // Both invalidate together with drr=0: core0 first, then core1, then core0 again.
      add("d1_grant0", 1,0,0,0,2'b11,2'b11, FREE,0, 'h500,'h600,0,0, 3,3,0,0,0,0, 0,0,0,0,0,0);
      add("d2_inv0",   1,0,0,0,2'b11,2'b11, FREE,0, 'h500,'h600,0,0, 3,3,2'b10,2'b10,0,0, 0,0,0,0,0,'h500);
      add("d3_done0",  1,0,0,0,2'b11,2'b11, FREE,0, 'h500,'h600,0,0, 3,2'b10,0,0,0,0, 0,0,0,0,0,0);
      add("d4_grant1", 1,0,0,0,2'b11,2'b11, FREE,0, 'h300,'h600,0,0, 3,3,0,0,0,0, 0,0,0,0,0,0);
      add("d5_inv1",   1,0,0,0,2'b11,2'b11, FREE,0, 'h300,'h600,0,0, 3,3,2'b01,2'b01,0,0, 0,0,0,0,'h600,0);
      add("d6_done1",  1,0,0,0,2'b11,2'b11, FREE,0, 'h300,'h600,0,0, 3,2'b01,0,0,0,0, 0,0,0,0,0,0);
      add("c1_grant",  1,0,0,0,2'b01,2'b01, FREE,0, 'h300,0,0,0, 3,3,0,0,0,0, 0,0,0,0,0,0);
      add("c2_inv",    1,0,0,0,2'b01,2'b01, FREE,0, 'h300,0,0,0, 3,3,2'b10,2'b10,0,0, 0,0,0,0,0,'h300);
      add("c3_done",   1,0,0,0,2'b01,2'b01, FREE,0, 'h300,0,0,0, 3,2'b10,0,0,0,0, 0,0,0,0,0,0);
      // Reset in FWD1 with drr=1; afterwards drr must be back at 0.
      add("f1_grant",  1,0,2'b01,0,0,0, FREE,0, 'h900,0,0,0, 3,3,0,0,0,0, 0,0,0,0,0,0);
      add("f2_snoop",  1,0,2'b01,0,0,0, FREE,0, 'h900,0,0,0, 3,3,2'b10,0,0,0, 0,0,0,0,0,'h900);
      add("f3_snpchk", 1,0,2'b01,0,2'b10,0, FREE,0, 'h900,'h900,0,'h55, 3,3,2'b10,0,0,0, 0,0,0,0,0,'h900);
      add("f4_fwd0",   1,0,2'b01,0,2'b10,0, ACCESS,0, 'h900,'h900,0,'h55, 3,0,2'b10,0,0,1, 'h900,'h55,'h55,0,0,'h900);
      add("f5_rst_fwd1",0,0,2'b01,0,2'b10,0, ACCESS,0, 'h904,'h904,0,'h66, 3,3,0,0,0,0, 0,0,0,0,0,0);
      add("f6_release",1,0,0,0,0,0, FREE,0, 0,0,0,0, 3,3,0,0,0,0, 0,0,0,0,0,0);
      add("f7_grant0", 1,0,0,0,2'b11,2'b11, FREE,0, 'hA00,'hB00,0,0, 3,3,0,0,0,0, 0,0,0,0,0,0);
      add("f8_inv0",   1,0,0,0,2'b11,2'b11, FREE,0, 'hA00,'hB00,0,0, 3,3,2'b10,2'b10,0,0, 0,0,0,0,0,'hA00);
      add("f9_done0",  1,0,0,0,2'b11,2'b11, FREE,0, 'hA00,'hB00,0,0, 3,2'b10,0,0,0,0, 0,0,0,0,0,0);
      add("f10_grant1",1,0,0,0,2'b10,2'b10, FREE,0, 0,'hB00,0,0, 3,3,0,0,0,0, 0,0,0,0,0,0);
      add("f11_inv1",  1,0,0,0,2'b10,2'b10, FREE,0, 0,'hB00,0,0, 3,3,2'b01,2'b01,0,0, 0,0,0,0,'hB00,0);
      add("f12_done1", 1,0,0,0,2'b10,2'b10, FREE,0, 0,'hB00,0,0, 3,2'b01,0,0,0,0, 0,0,0,0,0,0);
      // Core0 two-word writeback beats a pending core1 ifetch, which follows.
      add("e1_grant",  1,2'b10,0,2'b01,0,0, FREE,0, 'h700,0,'hD0,0, 3,3,0,0,0,0, 0,0,0,0,0,0);
      add("e2_wb0",    1,2'b10,0,2'b01,0,0, ACCESS,0, 'h700,0,'hD0,0, 3,2'b10,0,0,0,1, 'h700,'hD0,0,0,0,0);
      add("e3_wb1",    1,2'b10,0,2'b01,0,0, ACCESS,0, 'h704,0,'hD1,0, 3,2'b10,0,0,0,1, 'h704,'hD1,0,0,0,0);
      add("e4_wb_end", 1,2'b10,0,0,0,0, FREE,0, 'h704,0,'hD1,0, 3,3,0,0,0,1'b0, 'h704,'hD1,0,0,0,0);
      add("e5_igrant", 1,2'b10,0,0,0,0, FREE,0, 0,0,0,0, 3,3,0,0,0,0, 0,0,0,0,0,0);
      add("e6_ifetch", 1,2'b10,0,0,0,0, ACCESS,'h1234, 0,0,0,0, 2'b01,3,0,0,1,0, 'h80,0,'h1234,'h1234,0,0);
      // Icache round robin.
      add("g1_igrant0",1,2'b11,0,0,0,0, FREE,0, 0,0,0,0, 3,3,0,0,0,0, 0,0,0,0,0,0);
      add("g2_ifetch0",1,2'b11,0,0,0,0, ACCESS,'h5678, 0,0,0,0, 2'b10,3,0,0,1,0, 'h40,0,'h5678,'h5678,0,0);
      add("g3_igrant1",1,2'b11,0,0,0,0, FREE,0, 0,0,0,0, 3,3,0,0,0,0, 0,0,0,0,0,0);
      add("g4_ifetch1",1,2'b11,0,0,0,0, ACCESS,'h9ABC, 0,0,0,0, 2'b01,3,0,0,1,0, 'h80,0,'h9ABC,'h9ABC,0,0);

      @(negedge CLK);
      #1;
      check("reset_defaults", outs(),
            {2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0,
             32'hDEAD, 32'hDEAD, 32'h0, 32'h0, 32'hDEAD, 32'hDEAD});

      foreach (vecs[i]) apply(vecs[i]);

      // Core1 ifetch stalled by ERROR, BUSY and FREE before RAM finally answers.
      @(negedge CLK);
      iREN = 2'b10; ramstate = FREE; ramload = '0;
      #1;
      check("stall_grant", {iwait, ramREN}, {2'b11, 1'b0});
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         ramstate = (k == 0) ? ERROR : (k == 1) ? BUSY : FREE;
         #1;
         check($sformatf("stall_wait%0d", k), {iwait, ramREN, ramaddr}, {2'b11, 1'b1, 32'h80});
      end
      @(negedge CLK);
      ramstate = ACCESS; ramload = 32'hCAFE;
      #1;
      found = 1'b0;
      for (int k = 0; k < 4 && !found; k++) begin
         if (iwait == 2'b01) found = 1'b1;
         else begin
            @(negedge CLK);
            #1;
         end
      end
      check("stall_done", {31'b0, found}, 32'd1);
      check("stall_iload", iload[1], 32'hCAFE);
      @(negedge CLK);
      iREN = '0; ramstate = FREE;
      #1;
      check("stall_idle", {iwait, ramREN}, {2'b11, 1'b0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/coherence_ctrl.md
# coherence_ctrl

Snooping bus and coherence controller between the two cores' instruction/data caches and the single-ported RAM. It arbitrates cache requests, serves icache fetches and dcache fills and writebacks from RAM, and drives the snoop lines (`ccwait`, `ccinv`, `ccsnoopaddr`) into the peer dcache. When the peer holds a dirty copy, it routes that cache-to-cache forward both to the requester and to RAM. It sits directly downstream of each dcache's `cif` port and upstream of RAM.

## Interface
- `CPUS`, default 2: cache pairs served. Only 2 is supported; the peer of `i` is `~i`.
- `CLK`  in  1  clock
- `nRST`  in  1  asynchronous, active-low reset
- `iREN[CPUS]`  in  1  icache read request
- `iaddr[CPUS]`  in  32  icache word address
- `iwait[CPUS]`  out  1  icache stall; low for exactly the data cycle
- `iload[CPUS]`  out  32  fetched word
- `dREN[CPUS]`, `dWEN[CPUS]`  in  1  dcache read / write word request
- `daddr[CPUS]`, `dstore[CPUS]`  in  32  dcache word address / store data
- `cctrans[CPUS]`  in  1  dcache starts a coherence transaction
- `ccwrite[CPUS]`  in  1  transaction is a write intent (BusRdX / Inv)
- `dwait[CPUS]`  out  1  dcache stall; low for exactly the completion cycle
- `dload[CPUS]`  out  32  fill data
- `ccwait[CPUS]`  out  1  snoop active on this cache
- `ccinv[CPUS]`  out  1  invalidate snooped line
- `ccsnoopaddr[CPUS]`  out  32  snooped address
- `ramREN`, `ramWEN`  out  1  RAM read / write
- `ramaddr`, `ramstore`  out  32  RAM address / write data
- `ramload`  in  32  RAM read data
- `ramstate`  in  2  `ramstate_t`: FREE/BUSY/ACCESS/ERROR

## Operation
- **Output defaults in every state and during reset:** `iwait=dwait=1`; `ccwait=ccinv=0`; `ccsnoopaddr=0`; `ram*=0`; `iload=dload=ramload`.
- **Registers:**
  - `state`
  - `req`: granted cache
  - `drr`, `irr`: round-robin priority bits
- **IDLE grant:**
  - Dcache wins over icache.
  - Among dcaches requesting (`dWEN|dREN|cctrans`), `drr` picks the winner.
  - The winner's kind selects the next state:
    - `dWEN` → WB.
    - `dREN` → SNOOP.
    - `cctrans & ccwrite & ~dREN & ~dWEN` → INV.
  - Otherwise, if any `iREN`, `irr` picks the cache → IFETCH.
- **IFETCH:** `ramREN=1`, `ramaddr=iaddr[req]`. On ACCESS: `iwait[req]=0`, `irr<=~req`, → IDLE.
- **WB:**
  - Drive `ramWEN=dWEN[req]`, `ramaddr=daddr[req]`, `ramstore=dstore[req]`.
  - Each ACCESS: `dwait[req]=0`.
  - Stay in WB while `dWEN[req]`, so the two-word writeback or flush stream is not interleaved.
  - On `~dWEN[req]` → IDLE with `drr<=~req`.
- **SNOOP** (1 cycle): `ccwait[~req]=1`, `ccsnoopaddr[~req]=daddr[req]`, `ccinv[~req]=ccwrite[req]`. Next state:
  - `cctrans[~req]` seen the following cycle → FWD0.
  - Otherwise → RD0.
  - This decision is made in a one-cycle SNOOPCHK state that holds the same snoop outputs.
- **FWD0/FWD1:**
  - Drive `ramWEN=1`, `ramaddr=daddr[~req]`, `ramstore=dstore[~req]`, `dload[req]=dstore[~req]`.
  - On ACCESS: `dwait[req]=dwait[~req]=0`.
  - FWD0 → FWD1; FWD1 → IDLE, `drr<=~req`.
- **RD0/RD1:**
  - Drive `ramREN=1`, `ramaddr=daddr[req]`.
  - On ACCESS: `dwait[req]=0`.
  - RD0 → RD1 → IDLE, `drr<=~req`.
- **INV:**
  - Drive `ccwait[~req]=ccinv[~req]=1`, `ccsnoopaddr[~req]=daddr[req]`.
  - Next cycle, INVDONE: `dwait[req]=0` → IDLE, `drr<=~req`.
- **Snoop hold:** snoop outputs stay asserted through SNOOP, SNOOPCHK, FWD0/1 and RD0/1.
- **ramstate:** ERROR, BUSY and FREE are all treated as not-ACCESS, i.e. wait. The controller never times out.

## Timing
- **Data completion** is combinational on `ramstate==ACCESS` in the same cycle: `dwait`/`iwait` go low with `dload`/`iload` valid.
- **Minimum latency** with RAM ACCESS every cycle:
  - Dcache fill: 1 (grant) + 2 (snoop) + 2 words = 5 cycles from request to last `dwait` low.
  - Invalidate: 3 cycles.
  - Ifetch: 2 cycles.
- **Simultaneous dcache requests:** `drr` decides; the loser keeps its request asserted and is granted next IDLE.
- **Same block on both cores:** transactions are serialized, so the loser's fill observes the winner's post-transaction state through the snoop.
- **Reset mid-transaction:** `state=IDLE`, `drr=irr=0`, all outputs to defaults immediately (asynchronous).
- **Request drop:** the requester must hold its request until its `dwait` goes low. A request dropped mid-WB ends WB.

## Structure
- Add to `caches_types_pkg`: `cc_state_t` enum {IDLE, IFETCH, WB, SNOOP, SNOOPCHK, FWD0, FWD1, RD0, RD1, INV, INVDONE}.
- Use `ramstate_t` and `word_t` from `cpu_types_pkg`.
- One sub-module: `rr_arb2`, a 2-requester round-robin grant with a priority input. It is instantiated twice, once for dcache and once for icache.

## Test plan
- Core0 `dREN` at `0x100`, peer clean, RAM returns `0xAAAA`/`0xBBBB` → `ccwait[1]=1`, `ccinv[1]=0`, `dload[0]`=`0xAAAA` then `0xBBBB`, `ramREN` high.
- Core1 `dREN`+`ccwrite` at `0x200` while core0 holds it dirty with `0x11`/`0x22` → `ccinv[0]=1`, `cctrans[0]` seen, `dload[1]`=`0x11`/`0x22`, RAM written with both words, both `dwait` low together.
- Core0 INV at `0x300` → `ccwait[1]=ccinv[1]=1` for 1 cycle, `dwait[0]` low on cycle 3, no RAM access.
- Both dcaches request together, `drr=0` → core0 served first, core1 next, `drr` toggles.
- Core0 two-word WB while `iREN[1]` pending → both words written uninterrupted, then `iload[1]` served.
- `nRST` asserted in FWD1 → all `ccwait` and `ram*` low immediately, state IDLE.
